// File: rtl/dmem_map_pkg.sv
`default_nettype none
// ============================================================================
// dmem_map_pkg : dmem window defaults and port-arbiter state encoding
// Rev 1.0
// ============================================================================
package dmem_map_pkg;

  localparam logic [31:0] BASE_ADDR_DEF = 32'h1001_0000;
  localparam int          ADDR_W_DEF    = 11;
  localparam int          MAX_WAIT_DEF  = 4;
  localparam int          BURST_MAX_DEF = 8;

  typedef enum logic [1:0] {
    C_PRI   = 2'd0,
    D_FORCE = 2'd1,
    D_LOCK  = 2'd2
  } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/dmem_addr_map.sv
`default_nettype none
// ============================================================================
// dmem_addr_map : byte address -> dmem word index with range/alignment check
// Rev 1.0
// ============================================================================
module dmem_addr_map
  import dmem_map_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEF,
  parameter int          ADDR_W    = ADDR_W_DEF
) (
  input  logic [31:0]       addr_i,
  output logic [ADDR_W-1:0] idx_o,
  output logic              valid_o
);

  logic [31:0] w_off;

  // Upper offset bits nonzero means the word index is past DEPTH.
  always_comb begin
    w_off   = addr_i - BASE_ADDR;
    idx_o   = w_off[ADDR_W+1:2];
    valid_o = (addr_i >= BASE_ADDR) &&
              (w_off[1:0] == 2'b00) &&
              ((w_off >> (ADDR_W + 2)) == 32'd0);
  end

endmodule
`default_nettype wire

// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// dmem_port_arbiter : shares single-port dmem between CPU (C) and loader (D)
// Rev 1.0
// ============================================================================
module dmem_port_arbiter
  import dmem_map_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEF,
  parameter int          ADDR_W    = ADDR_W_DEF,
  parameter int          MAX_WAIT  = MAX_WAIT_DEF,
  parameter int          BURST_MAX = BURST_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [31:0]       c_addr,
  input  logic [31:0]       c_wdata,
  output logic [31:0]       c_rdata,
  output logic              c_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic              d_lock,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic [31:0]       d_rdata,
  output logic              d_ready,
  output logic              mem_w,
  output logic              mem_r,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              err,
  input  logic              err_clr
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam int BEAT_W = $clog2(BURST_MAX + 1);

  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);
  localparam logic [BEAT_W-1:0] BEAT_LIM = BEAT_W'(BURST_MAX);
  localparam logic [BEAT_W-1:0] BEAT_ONE = BEAT_W'(1);
  localparam logic              LOCK_OK  = (BURST_MAX > 1);

  arb_state_e        state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [BEAT_W-1:0] beat_q, beat_d, beat_n;
  logic              err_q, err_d;

  logic              gnt_c, gnt_d;
  logic [ADDR_W-1:0] c_idx, d_idx;
  logic              c_ok, d_ok;

  dmem_addr_map #(.BASE_ADDR(BASE_ADDR), .ADDR_W(ADDR_W)) u_map_c (
    .addr_i  (c_addr),
    .idx_o   (c_idx),
    .valid_o (c_ok)
  );

  dmem_addr_map #(.BASE_ADDR(BASE_ADDR), .ADDR_W(ADDR_W)) u_map_d (
    .addr_i  (d_addr),
    .idx_o   (d_idx),
    .valid_o (d_ok)
  );

  // Grant is gated by rst so nothing reaches dmem while reset is held.
  always_comb begin
    gnt_c = 1'b0;
    gnt_d = 1'b0;
    if (!rst) begin
      case (state_q)
        C_PRI: begin
          gnt_c = c_req;
          gnt_d = d_req & ~c_req;
        end
        D_FORCE: begin
          gnt_d = d_req;
          gnt_c = c_req & ~d_req;
        end
        D_LOCK:  gnt_d = d_req;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    beat_d  = beat_q;
    beat_n  = beat_q + BEAT_ONE;
    case (state_q)
      C_PRI: begin
        if (gnt_d) begin
          wait_d = '0;
          if (d_lock && LOCK_OK) begin
            state_d = D_LOCK;
            beat_d  = BEAT_ONE;
          end
        end else if (d_req) begin
          if (wait_q != WAIT_LIM) begin
            wait_d = wait_q + WAIT_ONE;
          end
          if (wait_d == WAIT_LIM) begin
            state_d = D_FORCE;
          end
        end
      end
      D_FORCE: begin
        wait_d  = '0;
        state_d = C_PRI;
        if (gnt_d && d_lock && LOCK_OK) begin
          state_d = D_LOCK;
          beat_d  = BEAT_ONE;
        end
      end
      D_LOCK: begin
        wait_d = '0;
        // The entry beat counts as beat 1, so the limit is checked on the incremented count.
        if (!d_req || !d_lock || beat_n == BEAT_LIM) begin
          state_d = C_PRI;
          beat_d  = '0;
        end else begin
          beat_d = beat_n;
        end
      end
      default: begin
        state_d = C_PRI;
        wait_d  = '0;
        beat_d  = '0;
      end
    endcase
  end

  always_comb begin
    err_d = err_q;
    if (err_clr) begin
      err_d = 1'b0;
    end
    if ((gnt_c && !c_ok) || (gnt_d && !d_ok)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= C_PRI;
      wait_q  <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
    end
  end

  // An invalid granted access completes but never touches dmem.
  always_comb begin
    mem_w     = 1'b0;
    mem_r     = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    c_rdata   = '0;
    d_rdata   = '0;
    if (gnt_c) begin
      mem_addr  = c_idx;
      mem_wdata = c_wdata;
      mem_w     = c_ok & c_we;
      mem_r     = c_ok & ~c_we;
      if (c_ok && !c_we) begin
        c_rdata = mem_rdata;
      end
    end else if (gnt_d) begin
      mem_addr  = d_idx;
      mem_wdata = d_wdata;
      mem_w     = d_ok & d_we;
      mem_r     = d_ok & ~d_we;
      if (d_ok && !d_we) begin
        d_rdata = mem_rdata;
      end
    end
  end

  assign c_ready = gnt_c;
  assign d_ready = gnt_d;
  assign err     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// tb_dmem_port_arbiter : directed self-checking bench with a behavioural dmem
// Rev 1.0
// ============================================================================
module tb_dmem_port_arbiter;
  import dmem_map_pkg::*;

  localparam logic [31:0] BASE = BASE_ADDR_DEF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        c_req = 1'b0, c_we = 1'b0;
  logic [31:0] c_addr = '0, c_wdata = '0, c_rdata;
  logic        c_ready;
  logic        d_req = 1'b0, d_we = 1'b0, d_lock = 1'b0;
  logic [31:0] d_addr = '0, d_wdata = '0, d_rdata;
  logic        d_ready;
  logic        mem_w, mem_r;
  logic [10:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        err;
  logic        err_clr = 1'b0;
  logic        mem_clr = 1'b1;

  logic [31:0] mem [0:2047];

  int n_checks = 0;
  int n_fail   = 0;
  int beat;

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 2048; i++) mem[i] <= '0;
    end else if (mem_w) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  dmem_port_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .c_req     (c_req),
    .c_we      (c_we),
    .c_addr    (c_addr),
    .c_wdata   (c_wdata),
    .c_rdata   (c_rdata),
    .c_ready   (c_ready),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_lock    (d_lock),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_ready   (d_ready),
    .mem_w     (mem_w),
    .mem_r     (mem_r),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .err       (err),
    .err_clr   (err_clr)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    // Reset with both ports requesting: nothing may be granted.
    c_req = 1'b1; d_req = 1'b1; c_we = 1'b1; d_we = 1'b1;
    c_addr = BASE; d_addr = BASE;
    #1;
    check_eq("rst_c_ready", c_ready, 0);
    check_eq("rst_d_ready", d_ready, 0);
    check_eq("rst_mem_w",   mem_w,   0);
    check_eq("rst_mem_r",   mem_r,   0);
    check_eq("rst_err",     err,     0);
    tick();
    rst = 1'b0; mem_clr = 1'b0; d_req = 1'b0;

    // C only: write then read back.
    c_req = 1'b1; c_we = 1'b1; c_addr = BASE + 32'h8; c_wdata = 32'hDEAD_BEEF;
    #1;
    check_eq("t1_wr_ready", c_ready,  1);
    check_eq("t1_wr_mem_w", mem_w,    1);
    check_eq("t1_wr_addr",  mem_addr, 2);
    tick();
    c_we = 1'b0;
    #1;
    check_eq("t1_rd_ready", c_ready,  1);
    check_eq("t1_rd_mem_r", mem_r,    1);
    check_eq("t1_rd_addr",  mem_addr, 2);
    check_eq("t1_rd_data",  c_rdata,  32'hDEAD_BEEF);
    tick();

    // Contention: C wins 4 cycles, D forced on the 5th, then C again.
    d_req = 1'b1; d_we = 1'b1; d_lock = 1'b0; d_addr = BASE + 32'h10; d_wdata = 32'h1111_2222;
    for (int i = 0; i < 6; i++) begin
      #1;
      check_eq($sformatf("t2_c_ready_%0d", i), c_ready, (i != 4));
      check_eq($sformatf("t2_d_ready_%0d", i), d_ready, (i == 4));
      tick();
    end
    c_req = 1'b0; d_req = 1'b0;
    #1;
    check_eq("t2_d_write", mem[4], 32'h1111_2222);
    tick();

    // Locked D burst of 10 requested beats: only 8 granted, C stalled meanwhile.
    beat = 0;
    d_req = 1'b1; d_lock = 1'b1; d_we = 1'b1; d_addr = BASE + 32'h40; d_wdata = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 1) begin
        c_req = 1'b1; c_we = 1'b0; c_addr = BASE + 32'h8;
      end
      #1;
      check_eq($sformatf("t3_d_ready_%0d", i), d_ready, (i < 8));
      check_eq($sformatf("t3_c_ready_%0d", i), c_ready, (i >= 8));
      if (d_ready) beat++;
      tick();
      d_addr = BASE + 32'h40 + 32'(4 * beat);
      d_wdata = 32'(beat);
    end
    d_req = 1'b0; d_lock = 1'b0; c_req = 1'b0;
    #1;
    check_eq("t3_last_beat", mem[23], 7);
    check_eq("t3_no_ninth",  mem[24], 0);
    tick();

    // Invalid accesses and sticky err.
    c_req = 1'b1; c_we = 1'b1; c_wdata = 32'hCAFE_F00D; c_addr = 32'h1000_FFFC;
    #1;
    check_eq("t4_low_ready", c_ready, 1);
    check_eq("t4_low_mem_w", mem_w,   0);
    tick();
    c_req = 1'b0;
    #1;
    check_eq("t4_low_err", err, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    #1;
    check_eq("t4_clr_err", err, 0);
    c_req = 1'b1; c_addr = 32'h1001_2000;
    #1;
    check_eq("t4_high_ready", c_ready, 1);
    check_eq("t4_high_mem_w", mem_w,   0);
    tick();
    c_req = 1'b0;
    #1;
    check_eq("t4_high_err", err, 1);
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h1001_0002; err_clr = 1'b1;
    #1;
    check_eq("t4_mis_ready", c_ready, 1);
    check_eq("t4_mis_mem_r", mem_r,   0);
    check_eq("t4_mis_rdata", c_rdata, 0);
    tick();
    c_req = 1'b0; err_clr = 1'b0;
    #1;
    check_eq("t4_set_wins", err, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    c_req = 1'b1; c_we = 1'b1; c_addr = 32'h1001_1FFC;
    #1;
    check_eq("t4_clr_err2",   err,      0);
    check_eq("t4_top_mem_w",  mem_w,    1);
    check_eq("t4_top_addr",   mem_addr, 11'h7FF);
    tick();
    c_req = 1'b0;
    #1;
    check_eq("t4_top_err",  err,       0);
    check_eq("t4_top_word", mem[2047], 32'hCAFE_F00D);
    tick();

    // Reset asserted during a locked D write beat.
    d_req = 1'b1; d_lock = 1'b1; d_we = 1'b1; d_addr = BASE + 32'h80; d_wdata = 32'hA5A5_0001;
    #1;
    check_eq("t5_beat0", d_ready, 1);
    tick();
    d_addr = BASE + 32'h84; d_wdata = 32'hA5A5_0002;
    #1;
    check_eq("t5_beat1_mem_w", mem_w, 1);
    #1;
    rst = 1'b1; c_req = 1'b1; c_we = 1'b0; c_addr = BASE + 32'h8;
    #1;
    check_eq("t5_rst_d_ready", d_ready, 0);
    check_eq("t5_rst_c_ready", c_ready, 0);
    check_eq("t5_rst_mem_w",   mem_w,   0);
    check_eq("t5_rst_d_rdata", d_rdata, 0);
    tick();
    rst = 1'b0; d_lock = 1'b0; d_we = 1'b0; d_addr = BASE + 32'h80;
    #1;
    check_eq("t5_word_kept",  mem[33], 0);
    check_eq("t5_prev_beat",  mem[32], 32'hA5A5_0001);
    check_eq("t5_c_wins",     c_ready, 1);
    check_eq("t5_d_waits",    d_ready, 0);
    check_eq("t5_c_rdata",    c_rdata, 32'hDEAD_BEEF);
    tick();

    // D only: served every cycle, then contention shows a fresh wait count.
    c_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      check_eq($sformatf("t6_d_ready_%0d", i), d_ready, 1);
      check_eq($sformatf("t6_d_rdata_%0d", i), d_rdata, 32'hA5A5_0001);
      tick();
    end
    c_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_eq($sformatf("t6_cont_d_%0d", i), d_ready, (i == 4));
      check_eq($sformatf("t6_cont_c_%0d", i), c_ready, (i != 4));
      tick();
    end
    c_req = 1'b0; d_req = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
